// File: rtl/gerenciador_status_pkg.sv
// rtl/gerenciador_status_pkg.sv - shared estado codes, FSM states and default stat deltas
package gerenciador_status_pkg;

    localparam logic [4:0] EST_INTRO      = 5'b00000;
    localparam logic [4:0] EST_IDLE       = 5'b00001;
    localparam logic [4:0] EST_DORMINDO   = 5'b00010;
    localparam logic [4:0] EST_COMENDO    = 5'b00100;
    localparam logic [4:0] EST_DANDO_AULA = 5'b01000;
    localparam logic [4:0] EST_MORTO      = 5'b10000;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FOME  = 2'd1,
        S_SONO  = 2'd2,
        S_FELIC = 2'd3
    } fsm_t;

    localparam logic [7:0]        DEF_INIT_VAL   = 8'd200;
    localparam logic signed [7:0] DEF_DECAY      = -8'sd1;
    localparam logic signed [7:0] DEF_FEED_INC   = 8'sd8;
    localparam logic signed [7:0] DEF_SLEEP_INC  = 8'sd4;
    localparam logic signed [7:0] DEF_TEACH_INC  = 8'sd6;
    localparam logic signed [7:0] DEF_TEACH_COST = -8'sd2;

endpackage

// File: rtl/gerenciador_status_soma.sv
// rtl/gerenciador_status_soma.sv - soma_saturada: unsigned stat plus signed delta, clamped to 0..255
module soma_saturada (
    input  logic [7:0]        stat,
    input  logic signed [7:0] delta,
    output logic [7:0]        result
);

    // Ten bits so that 255 + 127 cannot wrap before the clamp sees it
    logic signed [9:0] sum;

    always_comb begin
        sum = $signed({2'b00, stat}) + $signed({{2{delta[7]}}, delta});
        if (sum < 10'sd0) begin
            result = 8'd0;
        end else if (sum > 10'sd255) begin
            result = 8'd255;
        end else begin
            result = sum[7:0];
        end
    end

endmodule

// File: rtl/gerenciador_status.sv
// rtl/gerenciador_status.sv - pet stat registers updated each tick through one shared saturating adder
module gerenciador_status
    import gerenciador_status_pkg::*;
#(
    parameter int                TICK_DIV   = 25_000_000,
    parameter logic [7:0]        INIT_VAL   = DEF_INIT_VAL,
    parameter logic signed [7:0] DECAY      = DEF_DECAY,
    parameter logic signed [7:0] FEED_INC   = DEF_FEED_INC,
    parameter logic signed [7:0] SLEEP_INC  = DEF_SLEEP_INC,
    parameter logic signed [7:0] TEACH_INC  = DEF_TEACH_INC,
    parameter logic signed [7:0] TEACH_COST = DEF_TEACH_COST
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] estado,
    output logic [7:0] fome,
    output logic [7:0] sono,
    output logic [7:0] felicidade,
    output logic       busy,
    output logic       upd_done
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]     tick_cnt;
    logic              tick;
    fsm_t              state;
    logic [4:0]        est_q;
    logic [7:0]        cur_stat;
    logic signed [7:0] cur_delta;
    logic [7:0]        sum_out;
    logic [7:0]        new_val;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    // Operand mux for the single adder; unknown est_q codes get a zero delta, which freezes like MORTO
    always_comb begin
        cur_stat  = fome;
        cur_delta = 8'sd0;
        case (state)
            S_SONO:  cur_stat = sono;
            S_FELIC: cur_stat = felicidade;
            default: cur_stat = fome;
        endcase
        case (est_q)
            EST_IDLE:       cur_delta = DECAY;
            EST_COMENDO:    cur_delta = (state == S_FOME)  ? FEED_INC  : DECAY;
            EST_DORMINDO:   cur_delta = (state == S_SONO)  ? SLEEP_INC : DECAY;
            EST_DANDO_AULA: cur_delta = (state == S_FELIC) ? TEACH_INC : TEACH_COST;
            default:        cur_delta = 8'sd0;
        endcase
        new_val = (est_q == EST_INTRO) ? INIT_VAL : sum_out;
    end

    soma_saturada u_soma (
        .stat   (cur_stat),
        .delta  (cur_delta),
        .result (sum_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            state      <= S_WAIT;
            est_q      <= EST_IDLE;
            fome       <= INIT_VAL;
            sono       <= INIT_VAL;
            felicidade <= INIT_VAL;
            busy       <= 1'b0;
            upd_done   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            upd_done <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (tick) begin
                        est_q <= estado;
                        state <= S_FOME;
                        busy  <= 1'b1;
                    end
                end
                S_FOME: begin
                    fome  <= new_val;
                    state <= S_SONO;
                end
                S_SONO: begin
                    sono  <= new_val;
                    state <= S_FELIC;
                end
                S_FELIC: begin
                    felicidade <= new_val;
                    state      <= S_WAIT;
                    busy       <= 1'b0;
                    upd_done   <= 1'b1;
                end
                default: begin
                    state <= S_WAIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
